// File: rtl/m1_frame_checker.sv
// m1_frame_checker: checks framed 12-bit words (filler, two slot counters and the
// slot sequence), keeps error statistics and runs a HUNT/CHECK/LOCK frame-lock FSM.
module m1_frame_checker #(
    parameter int unsigned LOCK_FRAMES   = 4,
    parameter int unsigned UNLOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wordValid,
    input  logic [6:0]  wordIdx,
    input  logic [4:0]  cntGrp,
    input  logic [11:0] dataWord,
    output logic        locked,
    output logic        errPulse,
    output logic [15:0] errCnt,
    output logic [7:0]  seqErrCnt,
    output logic [9:0]  cnt1012,
    output logic [9:0]  cnt6012
);

    localparam int unsigned IDX_W    = 7;
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned ERR_W    = 16;
    localparam int unsigned SEQ_W    = 8;
    localparam int unsigned DATA_W   = 12;
    localparam int unsigned LOCK_W   = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned UNLOCK_W = $clog2(UNLOCK_FRAMES + 1);

    localparam logic [IDX_W-1:0]  SLOT_A    = IDX_W'(2);
    localparam logic [IDX_W-1:0]  SLOT_B    = IDX_W'(34);
    localparam logic [IDX_W-1:0]  SLOT_LAST = IDX_W'(127);
    localparam logic [DATA_W-1:0] FILLER    = DATA_W'(12'h002);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [LOCK_W-1:0]   clean_cnt, clean_nx;
    logic [UNLOCK_W-1:0] bad_cnt, bad_nx;
    logic                idx_seen, idx_seen_nx;
    logic [IDX_W-1:0]    prev_idx, prev_idx_nx;
    logic                ref_a_ok, ref_a_ok_nx;
    logic                ref_b_ok, ref_b_ok_nx;
    logic [CNT_W-1:0]    ref_a, ref_a_nx;
    logic [CNT_W-1:0]    ref_b, ref_b_nx;
    logic                frame_err, frame_err_nx;
    logic                locked_nx;
    logic                err_pulse_nx;
    logic [ERR_W-1:0]    err_cnt_nx;
    logic [SEQ_W-1:0]    seq_cnt_nx;
    logic [CNT_W-1:0]    cnt_a_nx, cnt_b_nx;

    logic             is_a, is_b;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] exp_b;
    logic             seq_err, fmt_err, fill_err, a_err, b_err;
    logic             word_err, frame_close, frame_bad;

    // Classify the current word and detect every error type it carries.
    always_comb begin
        is_a        = (wordIdx == SLOT_A);
        is_b        = (wordIdx == SLOT_B);
        cnt_val     = dataWord[10:1];
        exp_b       = (cntGrp == 5'd0) ? CNT_W'(ref_b + CNT_W'(1)) : ref_b;
        seq_err     = wordValid && idx_seen && (wordIdx != IDX_W'(prev_idx + IDX_W'(1)));
        fmt_err     = (is_a || is_b) && (dataWord[11] || dataWord[0]);
        fill_err    = !is_a && !is_b && (dataWord != FILLER);
        // A sequence break wipes the references, so this word becomes the new reference.
        a_err       = is_a && ref_a_ok && !seq_err && (cnt_val != CNT_W'(ref_a + CNT_W'(1)));
        b_err       = is_b && ref_b_ok && !seq_err && (cnt_val != exp_b);
        word_err    = wordValid && (seq_err || fmt_err || fill_err || a_err || b_err);
        frame_close = wordValid && (wordIdx == SLOT_LAST);
        frame_bad   = frame_err || word_err;
    end

    // Next-state logic: references, statistics and the frame-lock FSM.
    always_comb begin
        state_nx     = state;
        clean_nx     = clean_cnt;
        bad_nx       = bad_cnt;
        idx_seen_nx  = idx_seen;
        prev_idx_nx  = prev_idx;
        ref_a_ok_nx  = ref_a_ok;
        ref_b_ok_nx  = ref_b_ok;
        ref_a_nx     = ref_a;
        ref_b_nx     = ref_b;
        frame_err_nx = frame_err;
        err_pulse_nx = word_err;
        err_cnt_nx   = errCnt;
        seq_cnt_nx   = seqErrCnt;
        cnt_a_nx     = cnt1012;
        cnt_b_nx     = cnt6012;

        if (wordValid) begin
            idx_seen_nx = 1'b1;
            prev_idx_nx = wordIdx;

            if (seq_err) begin
                ref_a_ok_nx = 1'b0;
                ref_b_ok_nx = 1'b0;
                if (seqErrCnt != '1) begin
                    seq_cnt_nx = SEQ_W'(seqErrCnt + SEQ_W'(1));
                end
            end

            if (word_err && (errCnt != '1)) begin
                err_cnt_nx = ERR_W'(errCnt + ERR_W'(1));
            end

            // Counter values are latched and taken as reference even when errored.
            if (is_a) begin
                ref_a_ok_nx = 1'b1;
                ref_a_nx    = cnt_val;
                cnt_a_nx    = cnt_val;
            end
            if (is_b) begin
                ref_b_ok_nx = 1'b1;
                ref_b_nx    = cnt_val;
                cnt_b_nx    = cnt_val;
            end

            frame_err_nx = frame_bad;

            if (frame_close) begin
                frame_err_nx = 1'b0;
                unique case (state)
                    HUNT: begin
                        if (ref_a_ok_nx && ref_b_ok_nx) begin
                            state_nx = CHECK;
                            clean_nx = '0;
                        end
                    end
                    CHECK: begin
                        if (frame_bad) begin
                            clean_nx = '0;
                        end else if (clean_cnt == LOCK_W'(LOCK_FRAMES - 1)) begin
                            state_nx = LOCK;
                            clean_nx = '0;
                            bad_nx   = '0;
                        end else begin
                            clean_nx = LOCK_W'(clean_cnt + LOCK_W'(1));
                        end
                    end
                    LOCK: begin
                        if (!frame_bad) begin
                            bad_nx = '0;
                        end else if (bad_cnt == UNLOCK_W'(UNLOCK_FRAMES - 1)) begin
                            state_nx    = HUNT;
                            bad_nx      = '0;
                            ref_a_ok_nx = 1'b0;
                            ref_b_ok_nx = 1'b0;
                        end else begin
                            bad_nx = UNLOCK_W'(bad_cnt + UNLOCK_W'(1));
                        end
                    end
                    default: begin
                        state_nx = HUNT;
                    end
                endcase
            end
        end

        locked_nx = (state_nx == LOCK);
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            clean_cnt <= '0;
            bad_cnt   <= '0;
            idx_seen  <= 1'b0;
            prev_idx  <= '0;
            ref_a_ok  <= 1'b0;
            ref_b_ok  <= 1'b0;
            ref_a     <= '0;
            ref_b     <= '0;
            frame_err <= 1'b0;
            locked    <= 1'b0;
            errPulse  <= 1'b0;
            errCnt    <= '0;
            seqErrCnt <= '0;
            cnt1012   <= '0;
            cnt6012   <= '0;
        end else begin
            state     <= state_nx;
            clean_cnt <= clean_nx;
            bad_cnt   <= bad_nx;
            idx_seen  <= idx_seen_nx;
            prev_idx  <= prev_idx_nx;
            ref_a_ok  <= ref_a_ok_nx;
            ref_b_ok  <= ref_b_ok_nx;
            ref_a     <= ref_a_nx;
            ref_b     <= ref_b_nx;
            frame_err <= frame_err_nx;
            locked    <= locked_nx;
            errPulse  <= err_pulse_nx;
            errCnt    <= err_cnt_nx;
            seqErrCnt <= seq_cnt_nx;
            cnt1012   <= cnt_a_nx;
            cnt6012   <= cnt_b_nx;
        end
    end

endmodule
